// File: rtl/col_serializer.sv
// Unpacks two packed complex columns into one complex sample per accepted beat.
// Column 0 lanes 0..LANES-1 stream first, then column 1. Conjugation is optional and latched per load.
module col_serializer #(
  parameter int DW    = 16,
  parameter int LANES = 4,
  parameter int NCOL  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DW*LANES-1:0]      col0_r,
  input  logic [DW*LANES-1:0]      col0_i,
  input  logic [DW*LANES-1:0]      col1_r,
  input  logic [DW*LANES-1:0]      col1_i,
  input  logic                     conj,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DW-1:0]            out_r,
  output logic [DW-1:0]            out_i,
  output logic                     out_col,
  output logic [$clog2(LANES)-1:0] out_idx,
  output logic                     out_last
);

  localparam int NBEAT = NCOL * LANES;
  localparam int BW    = $clog2(NBEAT);
  localparam int IW    = $clog2(LANES);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t               state_reg;
  logic [BW-1:0]        beat_reg;
  logic [DW*LANES-1:0]  col0_r_reg, col0_i_reg, col1_r_reg, col1_i_reg;
  logic                 conj_reg;

  logic                 load, advance;
  logic [DW*LANES-1:0]  src0_r, src0_i, src1_r, src1_i;
  logic                 src_conj;
  logic [BW-1:0]        beat_next;
  logic [DW-1:0]        lane_r [NBEAT];
  logic [DW-1:0]        lane_i [NBEAT];
  logic [DW-1:0]        sel_r, sel_i, neg_i, out_i_next;

  assign in_ready = (state_reg == IDLE) |
                    ((state_reg == STREAM) & out_valid & out_ready & out_last);
  assign load     = in_valid & in_ready;
  assign advance  = out_valid & out_ready;

  // A fresh load presents its beat 0 straight from the input buses, so it
  // can follow the previous load's final beat with no bubble.
  assign src0_r    = load ? col0_r : col0_r_reg;
  assign src0_i    = load ? col0_i : col0_i_reg;
  assign src1_r    = load ? col1_r : col1_r_reg;
  assign src1_i    = load ? col1_i : col1_i_reg;
  assign src_conj  = load ? conj : conj_reg;
  assign beat_next = load ? '0 : beat_reg + BW'(1);

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_r[gi]         = src0_r[DW*(LANES-gi)-1 -: DW];
      assign lane_i[gi]         = src0_i[DW*(LANES-gi)-1 -: DW];
      assign lane_r[LANES + gi] = src1_r[DW*(LANES-gi)-1 -: DW];
      assign lane_i[LANES + gi] = src1_i[DW*(LANES-gi)-1 -: DW];
    end
  endgenerate

  assign sel_r = lane_r[beat_next];
  assign sel_i = lane_i[beat_next];
  // Negating the most negative value saturates to the most positive.
  assign neg_i = (sel_i == {1'b1, {(DW-1){1'b0}}}) ? {1'b0, {(DW-1){1'b1}}}
                                                    : ({DW{1'b0}} - sel_i);
  assign out_i_next = src_conj ? neg_i : sel_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      beat_reg   <= '0;
      col0_r_reg <= '0;
      col0_i_reg <= '0;
      col1_r_reg <= '0;
      col1_i_reg <= '0;
      conj_reg   <= 1'b0;
      out_valid  <= 1'b0;
      out_r      <= '0;
      out_i      <= '0;
      out_col    <= 1'b0;
      out_idx    <= '0;
      out_last   <= 1'b0;
    end else if (load || (advance && !out_last)) begin
      if (load) begin
        col0_r_reg <= col0_r;
        col0_i_reg <= col0_i;
        col1_r_reg <= col1_r;
        col1_i_reg <= col1_i;
        conj_reg   <= conj;
      end
      state_reg <= STREAM;
      beat_reg  <= beat_next;
      out_valid <= 1'b1;
      out_r     <= sel_r;
      out_i     <= out_i_next;
      out_col   <= beat_next[BW-1];
      out_idx   <= beat_next[IW-1:0];
      out_last  <= (beat_next == BW'(NBEAT - 1));
    end else if (advance) begin
      // Final beat taken with nothing queued: samples keep their last value.
      state_reg <= IDLE;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_col_serializer.sv
// Directed bench for col_serializer: table of loads with hand-computed samples,
// plus sequences for backpressure, back-to-back loads, mid-stream reset and ignored loads.
module tb_col_serializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] col0_r = '0, col0_i = '0, col1_r = '0, col1_i = '0;
  logic        conj = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_r, out_i;
  logic        out_col;
  logic [1:0]  out_idx;
  logic        out_last;

  int errors = 0;
  int checks = 0;

  col_serializer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .col0_r(col0_r), .col0_i(col0_i), .col1_r(col1_r), .col1_i(col1_i),
    .conj(conj), .out_valid(out_valid), .out_ready(out_ready),
    .out_r(out_r), .out_i(out_i), .out_col(out_col), .out_idx(out_idx),
    .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0]  c0r, c0i, c1r, c1i;
    logic         cj;
    logic [127:0] exp_r;   // beat n at [16*(8-n)-1 -: 16]
    logic [127:0] exp_i;
  } vec_t;

  vec_t vecs[3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_r_of(input int v, input int n);
    logic [127:0] w;
    w = vecs[v].exp_r;
    return w[16*(8-n)-1 -: 16];
  endfunction

  function automatic logic [15:0] exp_i_of(input int v, input int n);
    logic [127:0] w;
    w = vecs[v].exp_i;
    return w[16*(8-n)-1 -: 16];
  endfunction

  task automatic drive_bus(input int v);
    col0_r = vecs[v].c0r;
    col0_i = vecs[v].c0i;
    col1_r = vecs[v].c1r;
    col1_i = vecs[v].c1i;
    conj   = vecs[v].cj;
  endtask

  task automatic apply_load(input int v);
    drive_bus(v);
    in_valid = 1'b1;
    #1;
    check("load_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic check_beat(input int v, input int n);
    check("beat_valid", 32'(out_valid), 32'd1);
    check("beat_r",     32'(out_r),     32'(exp_r_of(v, n)));
    check("beat_i",     32'(out_i),     32'(exp_i_of(v, n)));
    check("beat_col",   32'(out_col),   32'(n / 4));
    check("beat_idx",   32'(out_idx),   32'(n % 4));
    check("beat_last",  32'(out_last),  32'(n == 7));
    check("beat_in_ready", 32'(in_ready), 32'((n == 7) && out_ready));
    $display("load %0d beat %0d: col=%0d idx=%0d r=%h i=%h last=%0d",
             v, n, out_col, out_idx, out_r, out_i, out_last);
  endtask

  task automatic stream(input int v, input int first, input int last_n);
    out_ready = 1'b1;
    #1;
    for (int n = first; n <= last_n; n++) begin
      check_beat(v, n);
      @(posedge clk); #1;
    end
  endtask

  task automatic check_idle(input string name, input logic [15:0] r, input logic [15:0] i);
    check({name, "_valid"},    32'(out_valid), 32'd0);
    check({name, "_in_ready"}, 32'(in_ready),  32'd1);
    check({name, "_r_hold"},   32'(out_r),     32'(r));
    check({name, "_i_hold"},   32'(out_i),     32'(i));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] prev_r, prev_i;
    logic [1:0]  prev_idx;
    logic        prev_ready, have_prev;
    int          hs;

    vecs[0] = '{c0r: 64'h0100_FF00_0080_0000, c0i: 64'h0,
                c1r: 64'h0000_0100_0000_0000, c1i: 64'h0, cj: 1'b0,
                exp_r: 128'h0100_FF00_0080_0000_0000_0100_0000_0000,
                exp_i: 128'h0};
    vecs[1] = '{c0r: 64'h0100_FF00_0080_0000, c0i: 64'h00C1_FF4A_8000_000C,
                c1r: 64'h0000_0100_0000_0000, c1i: 64'h0001_7FFF_FFFF_0000, cj: 1'b1,
                exp_r: 128'h0100_FF00_0080_0000_0000_0100_0000_0000,
                exp_i: 128'hFF3F_00B6_7FFF_FFF4_FFFF_8001_0001_0000};
    vecs[2] = '{c0r: 64'h1234_5678_9ABC_DEF0, c0i: 64'h8000_0001_7FFF_FFFF,
                c1r: 64'hAAAA_5555_0F0F_F0F0, c1i: 64'h1111_2222_3333_4444, cj: 1'b0,
                exp_r: 128'h1234_5678_9ABC_DEF0_AAAA_5555_0F0F_F0F0,
                exp_i: 128'h8000_0001_7FFF_FFFF_1111_2222_3333_4444};

    // Reset state
    repeat (2) @(posedge clk);
    #1; rst = 1'b0; #1;
    check("rst_valid",    32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready),  32'd1);
    check("rst_r",        32'(out_r),     32'd0);
    check("rst_i",        32'(out_i),     32'd0);
    check("rst_col",      32'(out_col),   32'd0);
    check("rst_idx",      32'(out_idx),   32'd0);
    check("rst_last",     32'(out_last),  32'd0);

    // Table-driven loads under continuous out_ready
    for (int v = 0; v < 3; v++) begin
      out_ready = 1'b1;
      apply_load(v);
      stream(v, 0, 7);
      check_idle("tbl_idle", exp_r_of(v, 7), exp_i_of(v, 7));
    end

    // Backpressure: out_ready pattern 1,0,0 repeating
    apply_load(2);
    hs = 0;
    have_prev = 1'b0;
    prev_ready = 1'b0;
    prev_r = '0; prev_i = '0; prev_idx = '0;
    for (int cyc = 0; cyc < 40 && hs < 8; cyc++) begin
      out_ready = (cyc % 3 == 0);
      #1;
      if (have_prev && !prev_ready) begin
        check("bp_stable_r",   32'(out_r),   32'(prev_r));
        check("bp_stable_i",   32'(out_i),   32'(prev_i));
        check("bp_stable_idx", 32'(out_idx), 32'(prev_idx));
      end
      check("bp_valid",    32'(out_valid), 32'd1);
      check("bp_in_ready", 32'(in_ready),  32'(out_ready && hs == 7));
      if (out_ready) begin
        check("bp_r",   32'(out_r),   32'(exp_r_of(2, hs)));
        check("bp_i",   32'(out_i),   32'(exp_i_of(2, hs)));
        check("bp_col", 32'(out_col), 32'(hs / 4));
        check("bp_idx", 32'(out_idx), 32'(hs % 4));
        $display("bp handshake %0d: r=%h i=%h", hs, out_r, out_i);
        hs++;
      end
      prev_r = out_r; prev_i = out_i; prev_idx = out_idx;
      prev_ready = out_ready; have_prev = 1'b1;
      @(posedge clk); #1;
    end
    check("bp_handshakes", 32'(hs), 32'd8);
    out_ready = 1'b1;
    #1;
    check_idle("bp_idle", exp_r_of(2, 7), exp_i_of(2, 7));

    // Back-to-back: second load accepted on the final beat of the first
    apply_load(0);
    stream(0, 0, 6);
    check_beat(0, 7);
    drive_bus(1);
    in_valid = 1'b1;
    #1;
    check("b2b_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("b2b_no_gap", 32'(out_valid), 32'd1);
    stream(1, 0, 7);
    check_idle("b2b_idle", exp_r_of(1, 7), exp_i_of(1, 7));

    // Reset mid-stream at beat 3, then a fresh load
    apply_load(2);
    stream(2, 0, 2);
    check("mrst_beat3_idx", 32'(out_idx), 32'd3);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; #1;
    check("mrst_valid",    32'(out_valid), 32'd0);
    check("mrst_in_ready", 32'(in_ready),  32'd1);
    check("mrst_r",        32'(out_r),     32'd0);
    check("mrst_i",        32'(out_i),     32'd0);
    check("mrst_col",      32'(out_col),   32'd0);
    check("mrst_idx",      32'(out_idx),   32'd0);
    check("mrst_last",     32'(out_last),  32'd0);
    apply_load(0);
    stream(0, 0, 7);
    check_idle("mrst_idle", exp_r_of(0, 7), exp_i_of(0, 7));

    // in_valid during STREAM with other data is ignored
    apply_load(0);
    stream(0, 0, 1);
    drive_bus(2);
    in_valid = 1'b1;
    stream(0, 2, 6);
    in_valid = 1'b0;
    stream(0, 7, 7);
    check_idle("ign_idle", exp_r_of(0, 7), exp_i_of(0, 7));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
